w_fetch_unit: RTL

Weight-tile fetch engine that answers the accelerator controller's `clr_w` / `w_read` / `switch` strobes and returns `w_done`. On a clear it latches a tile base address and length, then issues one memory read per cycle while `read` is high. It writes the returned words into the shadow bank of a ping-pong weight buffer and raises `done` once every word has landed. The systolic array reads the active bank concurrently; `switch` swaps the banks.

---
 rtl/w_fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/w_fetch_unit.sv
// Weight-tile fetch engine: streams a tile from memory into the shadow half of a ping-pong weight buffer.
// Latency: first request the cycle after clr, data lands RD_LAT cycles after each request, act_data is 1 cycle.
// Backpressure: read low pauses request issue while outstanding returns still drain; done holds until the next clr.
module w_fetch_unit #(
    parameter int DW     = 64,
    parameter int DEPTH  = 16,
    parameter int AW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         read,
    input  logic                         switch,
    input  logic [AW-1:0]                base_addr,
    input  logic [$clog2(DEPTH+1)-1:0]   tile_len,
    output logic                         done,
    output logic                         mem_rd_en,
    output logic [AW-1:0]                mem_addr,
    input  logic [DW-1:0]                mem_rdata,
    input  logic [$clog2(DEPTH)-1:0]     act_idx,
    output logic [DW-1:0]                act_data,
    output logic                         shadow_bank
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [AW-1:0]     base_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     len_in;
    logic [LW-1:0]     issue_cnt;
    logic [LW-1:0]     recv_cnt;
    logic [LW-1:0]     issue_inc;
    logic [LW-1:0]     recv_inc;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] vld_shift;
    logic              ret_vld;
    logic              wr_en;

    logic [DW-1:0]     bank0 [DEPTH];
    logic [DW-1:0]     bank1 [DEPTH];

    // Tiles longer than one bank are clamped to the bank size.
    assign len_in    = (tile_len > DEPTH_L) ? DEPTH_L : tile_len;

    // A clr in the same cycle suppresses the request so no stale read is left in flight.
    assign mem_rd_en = (state == S_ISSUE) && read && !clr && (issue_cnt < len_q);
    assign mem_addr  = base_q + AW'(issue_cnt);

    // Return tracking: the oldest stage of the valid pipe marks data on mem_rdata this cycle.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign vld_shift = mem_rd_en;
        end else begin : g_latn
            assign vld_shift = {vld_pipe[RD_LAT-2:0], mem_rd_en};
        end
    endgenerate

    assign ret_vld   = vld_pipe[RD_LAT-1];
    // Returns arriving with clr or rst belong to the abandoned tile and are dropped.
    assign wr_en     = ret_vld && !clr && !rst;
    assign issue_inc = issue_cnt + LW'(mem_rd_en);
    assign recv_inc  = recv_cnt + LW'(wr_en);
    assign done      = (state == S_DONE);

    // Next-state: clr restarts from any state; otherwise advance on issue/receive counts.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = (len_in == '0) ? S_DONE : S_ISSUE;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (recv_inc == len_q)
                        state_nxt = S_DONE;
                    else if (issue_inc == len_q)
                        state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    if (recv_inc == len_q)
                        state_nxt = S_DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Control registers: FSM, tile parameters, counters, valid pipe and bank select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            vld_pipe    <= '0;
            shadow_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (switch)
                shadow_bank <= ~shadow_bank;
            if (clr) begin
                base_q    <= base_addr;
                len_q     <= len_in;
                issue_cnt <= '0;
                recv_cnt  <= '0;
                vld_pipe  <= '0;
            end else begin
                issue_cnt <= issue_inc;
                recv_cnt  <= recv_inc;
                vld_pipe  <= vld_shift;
            end
        end
    end

    // Buffer write: returned words go to the current shadow bank in arrival order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (shadow_bank)
                bank1[recv_cnt[IW-1:0]] <= mem_rdata;
            else
                bank0[recv_cnt[IW-1:0]] <= mem_rdata;
        end
    end

    // Active-bank read port for the array, registered.
    always_ff @(posedge clk) begin
        if (rst)
            act_data <= '0;
        else
            act_data <= shadow_bank ? bank0[act_idx] : bank1[act_idx];
    end

endmodule
